// File: rtl/credit_pkg.sv
// Shared types and helpers for the credit-flow-controlled transmit link.
package credit_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } credit_state_t;

  // Width needed to hold every count from 0 up to and including credits.
  function automatic int cnt_w(input int credits);
    return $clog2(credits + 1);
  endfunction

endpackage

// File: rtl/credit_counter.sv
// Saturating up/down credit counter with a sticky overflow flag.
module credit_counter #(
  parameter int unsigned W    = 5,
  parameter int unsigned INIT = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         err
);

  localparam logic [W-1:0] MAX = W'(INIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= MAX;
      err <= 1'b0;
    end else if (inc && !dec) begin
      // A return with every slot already credited means the far end miscounted.
      if (cnt == MAX) begin
        err <= 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else if (dec && !inc && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/credit_tx.sv
// Transmit end of a credit-flow-controlled link with flush/drain sequencing.
module credit_tx
  import credit_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int CREDITS = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [WIDTH-1:0]            in_data,
  input  logic                        in_val,
  output logic                        in_rdy,
  output logic [WIDTH-1:0]            link_data,
  output logic                        link_val,
  input  logic                        credit_ret,
  input  logic                        flush,
  output logic                        flush_done,
  output logic [cnt_w(CREDITS)-1:0]   credit_cnt,
  output logic                        credit_low,
  output logic                        cred_err
);

  localparam int unsigned    CW   = cnt_w(CREDITS);
  localparam logic [CW-1:0]  FULL = CW'(CREDITS);
  localparam logic [CW-1:0]  LOW  = CW'(CREDITS / 4);

  credit_state_t state;
  credit_state_t state_nxt;
  logic          send;

  assign in_rdy     = (state == RUN) && (credit_cnt != '0);
  assign send       = in_val && in_rdy;
  assign flush_done = (state == DONE);
  assign credit_low = (credit_cnt < LOW);

  credit_counter #(
    .W    (CW),
    .INIT (CREDITS)
  ) u_counter (
    .clk   (clk),
    .reset (reset),
    .inc   (credit_ret),
    .dec   (send),
    .cnt   (credit_cnt),
    .err   (cred_err)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (flush) state_nxt = DRAIN;
      // Quiet only once every credit is back and the last word has left the register.
      DRAIN:   if ((credit_cnt == FULL) && !link_val) state_nxt = DONE;
      DONE:    state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      link_val  <= 1'b0;
      link_data <= '0;
    end else begin
      state    <= state_nxt;
      link_val <= send;
      if (send) begin
        link_data <= in_data;
      end
    end
  end

endmodule

// File: tb/tb_credit_tx.sv
// Directed bench for credit_tx (WIDTH=8, CREDITS=4) with a link-word scoreboard.
module tb_credit_tx;

  localparam int WIDTH   = 8;
  localparam int CREDITS = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_val = 1'b0;
  logic             in_rdy;
  logic [WIDTH-1:0] link_data;
  logic             link_val;
  logic             credit_ret = 1'b0;
  logic             flush = 1'b0;
  logic             flush_done;
  logic [2:0]       credit_cnt;
  logic             credit_low;
  logic             cred_err;

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [WIDTH-1:0] exp_q[$];

  credit_tx #(
    .WIDTH   (WIDTH),
    .CREDITS (CREDITS)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_val     (in_val),
    .in_rdy     (in_rdy),
    .link_data  (link_data),
    .link_val   (link_val),
    .credit_ret (credit_ret),
    .flush      (flush),
    .flush_done (flush_done),
    .credit_cnt (credit_cnt),
    .credit_low (credit_low),
    .cred_err   (cred_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_status(input string tag, input int cnt, input int rdy,
                              input int low, input int err, input int done);
    check({tag, ".credit_cnt"}, int'(credit_cnt), cnt);
    check({tag, ".in_rdy"},     int'(in_rdy),     rdy);
    check({tag, ".credit_low"}, int'(credit_low), low);
    check({tag, ".cred_err"},   int'(cred_err),   err);
    check({tag, ".flush_done"}, int'(flush_done), done);
  endtask

  // Scoreboard monitor: every link word must match the next queued expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && link_val) begin
        if (exp_q.size() == 0) begin
          check("link_unexpected_word", int'(link_data), -1);
        end else begin
          check("link_data", int'(link_data), int'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    // Reset
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check_status("reset", 4, 1, 0, 0, 0);
    check("reset.link_val",  int'(link_val),  0);
    check("reset.link_data", int'(link_data), 0);

    // Credit exhaustion: 0x11..0x14 go out, 0x15 is held upstream
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h12);
    exp_q.push_back(8'h13);
    exp_q.push_back(8'h14);
    in_val = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = 8'(8'h11 + i);
      check($sformatf("exhaust.in_rdy[%0d]", i), int'(in_rdy), (i < 4) ? 1 : 0);
      tick();
      check($sformatf("exhaust.link_val[%0d]", i), int'(link_val), (i < 4) ? 1 : 0);
    end
    check_status("exhausted", 0, 0, 1, 0, 0);

    // Return unblocks: no same-cycle bypass, so 0x15 leaves one cycle later
    credit_ret = 1'b1;
    tick();
    credit_ret = 1'b0;
    check("unblock.link_val_hold", int'(link_val), 0);
    check_status("unblock", 1, 1, 0, 0, 0);
    exp_q.push_back(8'h15);
    tick();
    in_val = 1'b0;
    check("unblock.link_val", int'(link_val), 1);
    check_status("unblock_sent", 0, 0, 1, 0, 0);

    // Simultaneous send and return at credit_cnt=2
    credit_ret = 1'b1;
    tick();
    tick();
    check_status("sim_start", 2, 1, 0, 0, 0);
    in_val = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 8'(8'h21 + i);
      exp_q.push_back(8'(8'h21 + i));
      tick();
      check($sformatf("sim.credit_cnt[%0d]", i), int'(credit_cnt), 2);
    end
    in_val = 1'b0;
    credit_ret = 1'b0;

    // Overflow: returns beyond CREDITS saturate and set the sticky error
    credit_ret = 1'b1;
    tick();
    tick();
    credit_ret = 1'b0;
    check_status("full", 4, 1, 0, 0, 0);
    credit_ret = 1'b1;
    tick();
    credit_ret = 1'b0;
    check_status("overflow", 4, 1, 0, 1, 0);
    tick();
    tick();
    check("overflow.sticky", int'(cred_err), 1);

    // Flush with two words outstanding
    in_val = 1'b1;
    in_data = 8'h31;
    exp_q.push_back(8'h31);
    tick();
    in_data = 8'h32;
    exp_q.push_back(8'h32);
    tick();
    in_val = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_val = 1'b1;
    in_data = 8'h99;
    check_status("drain0", 2, 0, 0, 1, 0);
    tick();
    tick();
    check_status("drain2", 2, 0, 0, 1, 0);
    credit_ret = 1'b1;
    tick();
    tick();
    credit_ret = 1'b0;
    check_status("drain_full", 4, 0, 0, 1, 0);
    tick();
    in_val = 1'b0;
    check_status("flush_done", 4, 0, 0, 1, 1);
    tick();
    check_status("after_flush", 4, 1, 0, 1, 0);

    // Flush with nothing outstanding: flush_done two cycles after flush
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("idle_flush.c1", int'(flush_done), 0);
    tick();
    check("idle_flush.c2", int'(flush_done), 1);
    tick();
    check("idle_flush.c3", int'(flush_done), 0);
    check("idle_flush.in_rdy", int'(in_rdy), 1);

    // Reset mid-operation while draining with credit_cnt=1
    in_val = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 8'(8'h41 + i);
      exp_q.push_back(8'(8'h41 + i));
      tick();
    end
    in_val = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_status("pre_reset", 1, 0, 0, 1, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_status("mid_reset", 4, 1, 0, 0, 0);
    check("mid_reset.link_val", int'(link_val), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("mid_reset.no_done[%0d]", i), int'(flush_done), 0);
    end

    @(negedge clk);
    #1;
    check("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
